fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch front end and the consumer of the execute stage's branch/jump redirect (flush + target). It generates sequential PCs and issues word fetches to instruction memory over a valid/ready request channel. It accepts in-order responses into a small buffer and presents {pc, inst} to decode. On a redirect it discards every in-flight and buffered instruction from the old stream and restarts at the target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, instruction buffer entries (>=1); also the cap on outstanding requests plus buffered entries
CNT_W, 2, width of the outstanding/drop counters; must hold BUF_DEPTH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid, in request order, 1 per request; no backpressure
imem_rsp_data  in  32  instruction word
if_valid  out  1  buffer head valid to decode
if_ready  in  1  decode accepts head (low = stall)
if_pc  out  32  PC of head instruction
if_inst  out  32  head instruction

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0. Internal state: fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, buffer empty, state=BOOT.
- State machine:
  - BOOT: lasts exactly one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - DRAIN: entered on redirect when in-flight requests must be discarded.
  - RUN -> DRAIN: on redirect_valid when the post-update outstanding count > 0.
  - DRAIN -> RUN: when drop_cnt reaches 0.
- Request issue: imem_req_valid=1 only in RUN, and only when outstanding + buffer occupancy < BUF_DEPTH, so a response always has a slot. imem_req_addr=fetch_pc. On handshake, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding++.
- Request stability: valid/addr hold while ready=0, unless a redirect occurs.
- Response: on imem_rsp_valid, outstanding--.
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Otherwise: push {rsp_pc, data} to the buffer and rsp_pc += 4.
- Downstream: if_valid/if_pc/if_inst show the buffer head; pop on if_valid & if_ready. A push and a pop in the same cycle are both legal when full or empty. Zero-latency bypass is not required: a response is visible at the earliest the next cycle.
- Redirect (any state; takes priority over everything else that cycle):
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - Buffer flushed; if_valid=0 next cycle; any same-cycle pop is ignored.
  - drop_cnt = outstanding after this cycle's events. A request handshaked this cycle counts as old-stream. A response arriving this cycle is discarded and not counted.
  - imem_req_valid may drop to 0 without a handshake the cycle after a redirect.
  - Redirect in DRAIN reloads drop_cnt the same way.
- Latency: redirect in cycle N -> earliest request at the target in N+1 (if drop_cnt=0) -> earliest if_valid in N+3 with 1-cycle memory.
- Back-to-back redirects in consecutive cycles: the last one wins.
- Reset mid-operation clears everything asynchronously; responses to pre-reset requests are not the block's responsibility (memory is reset too).
- Assertions: imem_rsp_valid with outstanding==0 is an error; so are counter underflow and buffer overflow.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_redirects[31:0] (redirect_valid cycles) and perf_dropped[31:0] (responses discarded via drop_cnt). Both reset to 0 and saturate at 0xFFFF_FFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr as data, if_ready=1 -> requests 0x0,0x4,0x8... and if_pc==if_inst for each, in order.
- if_ready=0 for 10 cycles after the first instruction -> buffer holds 2 entries, imem_req_valid=0, no lost or duplicated instruction after release.
- Two requests outstanding (0x8,0xC), then redirect_valid with redirect_pc=0x103 -> both responses dropped, next request 0x100, first if_pc=0x100, perf_dropped=2.
- Redirect in the same cycle as a request handshake to 0x10 and a response for 0xC -> both discarded, no if_valid for 0xC/0x10, restart at the target.
- Redirects to 0x200 then 0x300 on consecutive cycles -> only 0x300 stream delivered.
- imem_req_ready=0 for 5 cycles -> imem_req_addr stable at 0x4, no fetch_pc advance. fetch_pc=0xFFFF_FFFC -> next request address 0x0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's handshake and bus signals.
//   redirect_*  : branch/jump redirect from execute into fetch
//   imem_req_*  : fetch request channel to instruction memory (valid/ready)
//   imem_rsp_*  : in-order response channel from instruction memory
//   if_*        : instruction channel to decode (valid/ready)
// master = fetch unit side, slave = environment (execute, memory, decode).
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_inst,
    input  if_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_inst,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Issues sequential word fetches,
// buffers in-order responses and presents {pc, inst} to decode. A redirect
// flushes the buffer and discards responses still in flight for the old stream.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fetch_unit_if.master (redirect, imem request/response, decode)
//   perf_redirects, perf_dropped : only when FETCH_PERF_CNT_EN is defined;
//                saturating counts of redirect cycles and dropped responses
//
// state    | meaning
// ST_BOOT  | one cycle after reset release, no requests
// ST_RUN   | normal sequential fetch
// ST_DRAIN | discarding old-stream responses, no requests
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          CNT_W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_redirects,
  output logic [31:0]  perf_dropped
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];

  logic             req_fire, push, pop, drop;
  logic [CNT_W-1:0] out_after;
  logic [CNT_W:0]   in_use;
  logic [31:0]      redir_tgt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outstanding requests plus buffered entries never exceed BUF_DEPTH, so every
  // response is guaranteed a buffer slot and the response channel needs no ready.
  assign in_use             = {1'b0, out_cnt_q} + {1'b0, occ_q};
  assign bus.imem_req_valid = (state_q == ST_RUN) && (in_use < (CNT_W+1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = (occ_q != '0);
  assign bus.if_pc          = buf_pc_q[rd_ptr_q];
  assign bus.if_inst        = buf_inst_q[rd_ptr_q];

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign out_after = out_cnt_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
  assign drop      = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q != '0);
  assign push      = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q == '0);
  assign pop       = bus.if_valid && bus.if_ready && !bus.redirect_valid;
  assign redir_tgt = {bus.redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_after;
    drop_cnt_d = drop_cnt_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;

    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream,
      // including a request accepted this very cycle.
      fetch_pc_d = redir_tgt;
      rsp_pc_d   = redir_tgt;
      drop_cnt_d = out_after;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      state_d    = (out_after != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop)     drop_cnt_d = drop_cnt_q - 1'b1;
      if (push) begin
        buf_pc_d[wr_ptr_q]   = rsp_pc_q;
        buf_inst_d[wr_ptr_q] = bus.imem_rsp_data;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
        rsp_pc_d             = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_DRAIN: if (drop_cnt_d == '0) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_dropped_d   = perf_dropped_q;
    if (bus.redirect_valid && (perf_redirects_q != '1)) perf_redirects_d = perf_redirects_q + 32'd1;
    if (drop && (perf_dropped_q != '1))                 perf_dropped_d   = perf_dropped_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects_q <= '0;
      perf_dropped_q   <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_dropped_q   <= perf_dropped_d;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_dropped   = perf_dropped_q;
`endif

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (out_cnt_q != '0));
  a_drop_le_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= out_cnt_q);
  a_buf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (occ_q < CNT_W'(BUF_DEPTH)));

endmodule
